hls_deadlock_monitor: RTL and testbench

Parametrised runtime deadlock monitor for co-simulation and on-chip debug of HLS dataflow regions with N processes. Each cycle it builds a blocked-process wait-for graph from per-process blocked flags and per-channel wait edges, and requires that graph to stay stable for a programmable number of cycles. It then computes the transitive closure and reports every process that lies on a dependency cycle, with a sticky detect flag and a one-hot origin. It generalises the fixed two-process mem_read/mem_write pair check to arbitrary N, self-loops and multi-process rings.

---
 rtl/hls_deadlock_monitor_if.sv | 24 ++
 rtl/hls_deadlock_monitor.sv | 134 +++++++++++++
 tb/tb_hls_deadlock_monitor.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hls_deadlock_monitor_if.sv
// Control/report bundle for hls_deadlock_monitor. The master drives the per-process
// blocked flags and wait edges; the slave (the monitor) returns the deadlock report.
interface hls_deadlock_monitor_if #(
   parameter int N_PROC = 4
);
   logic                       enable;
   logic                       clear;
   logic [N_PROC-1:0]          blocked;
   logic [N_PROC*N_PROC-1:0]   wait_vec;
   logic                       scan_busy;
   logic                       dl_detect;
   logic [N_PROC-1:0]          dl_members;
   logic [N_PROC-1:0]          dl_origin;

   modport master (
      output enable, clear, blocked, wait_vec,
      input  scan_busy, dl_detect, dl_members, dl_origin
   );

   modport slave (
      input  enable, clear, blocked, wait_vec,
      output scan_busy, dl_detect, dl_members, dl_origin
   );
endinterface

// File: rtl/hls_deadlock_monitor.sv
// Wait-for-graph deadlock monitor: waits for a stable blocked graph, then runs
// N_PROC-1 transitive-closure steps and reports every process on a cycle.
module hls_deadlock_monitor #(
   parameter int N_PROC        = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   hls_deadlock_monitor_if.slave bus
);
   localparam int SW = (N_PROC > 2) ? $clog2(N_PROC) : 1;
   localparam logic [7:0]    CNT_LAST  = 8'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(N_PROC - 2);

   typedef enum logic [2:0] {IDLE, ARM, SCAN, NODL, REPORT} state_t;
   typedef logic [N_PROC-1:0][N_PROC-1:0] mat_t;

   state_t            state;
   mat_t              e, e_q, s, r, r_nxt;
   logic [7:0]        cnt;
   logic [SW-1:0]     step;
   logic [N_PROC-1:0] diag, origin;
   logic              busy_q, detect_q;
   logic [N_PROC-1:0] members_q, origin_q;

   // Edge [i][j] only counts when both ends are stalled; flat index i*N_PROC+j.
   always_comb begin
      e     = '0;
      r_nxt = r;
      diag  = '0;
      for (int i = 0; i < N_PROC; i++) begin
         for (int j = 0; j < N_PROC; j++) begin
            e[i][j] = bus.wait_vec[i*N_PROC+j] & bus.blocked[i] & bus.blocked[j];
            for (int k = 0; k < N_PROC; k++)
               r_nxt[i][j] = r_nxt[i][j] | (r[i][k] & s[k][j]);
         end
      end
      for (int i = 0; i < N_PROC; i++)
         diag[i] = r_nxt[i][i];
      origin = diag & (~diag + {{(N_PROC-1){1'b0}}, 1'b1});
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         step      <= '0;
         e_q       <= '0;
         s         <= '0;
         r         <= '0;
         busy_q    <= 1'b0;
         detect_q  <= 1'b0;
         members_q <= '0;
         origin_q  <= '0;
      end else begin
         e_q <= e;
         if (bus.clear) begin
            detect_q  <= 1'b0;
            members_q <= '0;
            origin_q  <= '0;
         end
         // A clear landing on the last closure step also discards that result.
         if (bus.clear && (state == REPORT || (state == SCAN && step == STEP_LAST))) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
         end else if (!bus.enable) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state  <= ARM;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
               ARM: begin
                  if (e != '0 && e == e_q) begin
                     if (cnt == CNT_LAST) begin
                        state <= SCAN;
                        s     <= e;
                        r     <= e;
                        step  <= '0;
                     end else begin
                        cnt <= cnt + 8'd1;
                     end
                  end else begin
                     cnt <= '0;
                  end
               end
               SCAN: begin
                  if (e != s) begin
                     state <= ARM;
                     cnt   <= '0;
                  end else begin
                     r    <= r_nxt;
                     step <= step + 1'b1;
                     if (step == STEP_LAST) begin
                        busy_q <= 1'b0;
                        if (diag != '0) begin
                           state     <= REPORT;
                           detect_q  <= 1'b1;
                           members_q <= diag;
                           origin_q  <= origin;
                        end else begin
                           state <= NODL;
                        end
                     end
                  end
               end
               // Static acyclic stall: wait for the graph to move before rescanning.
               NODL: begin
                  if (e != s) begin
                     state  <= ARM;
                     cnt    <= '0;
                     busy_q <= 1'b1;
                  end
               end
               REPORT: ;
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.scan_busy  = busy_q;
   assign bus.dl_detect  = detect_q;
   assign bus.dl_members = members_q;
   assign bus.dl_origin  = origin_q;
endmodule

// File: tb/tb_hls_deadlock_monitor.sv
// Bench for hls_deadlock_monitor: directed timing/report cases plus random graphs
// checked every cycle against a reachability-based reference model.
module tb_hls_deadlock_monitor;
   localparam int N  = 4;
   localparam int ST = 8;
   localparam int NN = N * N;
   localparam int P_IDLE = 0, P_ARM = 1, P_SCAN = 2, P_NODL = 3, P_REPORT = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   hls_deadlock_monitor_if #(.N_PROC(N)) bus ();
   hls_deadlock_monitor_if #(.N_PROC(2)) bus2 ();

   hls_deadlock_monitor #(.N_PROC(N), .STABLE_CYCLES(ST)) dut (
      .clock(clock), .reset(reset), .bus(bus.slave));
   hls_deadlock_monitor #(.N_PROC(2), .STABLE_CYCLES(8)) dut2 (
      .clock(clock), .reset(reset), .bus(bus2.slave));

   int checks = 0;
   int errs   = 0;

   // Reference model state: phase, stable-sample run, scan progress, snapshot.
   int            ph, run, k;
   logic [NN-1:0] m_prev, m_s;
   logic          m_det;
   logic [N-1:0]  m_mem, m_org;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [NN-1:0] edg(input int i, input int j);
      logic [NN-1:0] v;
      v = '0;
      v[i*N+j] = 1'b1;
      return v;
   endfunction

   function automatic logic [NN-1:0] eff(input logic [N-1:0] b, input logic [NN-1:0] w);
      logic [NN-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            v[i*N+j] = w[i*N+j] && b[i] && b[j];
      return v;
   endfunction

   // Process i is a member iff it can reach itself (Floyd-Warshall closure).
   function automatic logic [N-1:0] on_cycle(input logic [NN-1:0] g);
      bit reach [N][N];
      logic [N-1:0] m;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            reach[i][j] = g[i*N+j];
      for (int x = 0; x < N; x++)
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if (reach[i][x] && reach[x][j]) reach[i][j] = 1'b1;
      m = '0;
      for (int i = 0; i < N; i++) m[i] = reach[i][i];
      return m;
   endfunction

   function automatic logic [N-1:0] lowest(input logic [N-1:0] m);
      for (int i = 0; i < N; i++)
         if (m[i]) return N'(1) << i;
      return '0;
   endfunction

   task automatic model_reset();
      ph = P_IDLE; run = 0; k = 0;
      m_prev = '0; m_s = '0;
      m_det = 1'b0; m_mem = '0; m_org = '0;
   endtask

   task automatic model_step();
      logic [NN-1:0] g;
      logic [N-1:0]  mem;
      g = eff(bus.blocked, bus.wait_vec);
      if (bus.clear) begin
         m_det = 1'b0; m_mem = '0; m_org = '0;
      end
      if (bus.clear && (ph == P_REPORT || (ph == P_SCAN && k == N-2))) begin
         ph = P_IDLE; run = 0;
      end else if (!bus.enable) begin
         ph = P_IDLE; run = 0;
      end else begin
         case (ph)
            P_IDLE: begin ph = P_ARM; run = 0; end
            P_ARM: begin
               if (g != '0 && g == m_prev) begin
                  if (run + 1 == ST) begin ph = P_SCAN; m_s = g; k = 0; end
                  else run++;
               end else run = 0;
            end
            P_SCAN: begin
               if (g != m_s) begin ph = P_ARM; run = 0; end
               else if (k == N-2) begin
                  mem = on_cycle(m_s);
                  if (mem != '0) begin
                     ph = P_REPORT; m_det = 1'b1; m_mem = mem; m_org = lowest(mem);
                  end else ph = P_NODL;
               end else k++;
            end
            P_NODL: if (g != m_s) begin ph = P_ARM; run = 0; end
            default: ;
         endcase
      end
      m_prev = g;
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) model_step();
      @(negedge clock);
      #1;
   endtask

   task automatic drive(input logic en, input logic clr, input logic [N-1:0] b, input logic [NN-1:0] w);
      bus.enable = en; bus.clear = clr; bus.blocked = b; bus.wait_vec = w;
   endtask

   // Leaves the DUT in ARM with cnt=0 and sticky outputs cleared.
   task automatic restart();
      drive(1'b0, 1'b1, '0, '0); tick();
      drive(1'b1, 1'b0, '0, '0); tick();
   endtask

   task automatic run_until(input int maxc, output int at);
      at = -1;
      for (int c = 1; c <= maxc && at < 0; c++) begin
         tick();
         if (bus.dl_detect) at = c;
      end
   endtask

   always @(negedge clock)
      if (reset)
         chk("model", {22'd0, bus.scan_busy, bus.dl_detect, bus.dl_members, bus.dl_origin},
             {22'd0, (ph == P_ARM || ph == P_SCAN), m_det, m_mem, m_org});

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [NN-1:0] ring, chain, g;
      logic [N-1:0]  bl, b;
      int at, hold;
      ring  = edg(0,1) | edg(1,2) | edg(2,3) | edg(3,0);
      chain = edg(0,1) | edg(1,2);
      model_reset();
      drive(1'b0, 1'b0, '0, '0);
      bus2.enable = 1'b0; bus2.clear = 1'b0; bus2.blocked = '0; bus2.wait_vec = '0;
      #1;
      chk("reset_out", {22'd0, bus.scan_busy, bus.dl_detect, bus.dl_members, bus.dl_origin}, 0);
      @(negedge clock); #1 reset = 1'b1;

      // Four-process ring: latency STABLE+N-1, then clear.
      restart();
      drive(1'b1, 1'b0, 4'hF, ring); tick();
      run_until(40, at);
      chk("ring_latency", at, 11);
      chk("ring_members", bus.dl_members, 4'b1111);
      chk("ring_origin", bus.dl_origin, 4'b0001);
      drive(1'b1, 1'b1, 4'hF, ring); tick();
      drive(1'b1, 1'b0, 4'hF, ring);
      chk("clear_detect", bus.dl_detect, 0);
      chk("clear_members", bus.dl_members, 0);
      chk("clear_busy", bus.scan_busy, 0);

      // Acyclic chain parks in NODL; closing it triggers a rescan.
      restart();
      drive(1'b1, 1'b0, 4'b0111, chain); tick();
      repeat (20) tick();
      chk("chain_detect", bus.dl_detect, 0);
      chk("chain_busy", bus.scan_busy, 0);
      drive(1'b1, 1'b0, 4'b0111, chain | edg(2,0)); tick();
      run_until(40, at);
      chk("chain_close_latency", at, 11);
      chk("chain_members", bus.dl_members, 4'b0111);
      chk("chain_origin", bus.dl_origin, 4'b0001);

      // One-cycle drop of blocked[2] at cnt=5 restarts the window.
      restart();
      drive(1'b1, 1'b0, 4'hF, ring); tick();
      repeat (5) tick();
      drive(1'b1, 1'b0, 4'b1011, ring); tick();
      drive(1'b1, 1'b0, 4'hF, ring);
      run_until(40, at);
      chk("glitch_arm_latency", 6 + at, 18);

      // Same drop during the second closure step aborts the scan.
      restart();
      drive(1'b1, 1'b0, 4'hF, ring); tick();
      repeat (9) tick();
      drive(1'b1, 1'b0, 4'b1011, ring); tick();
      chk("abort_busy", bus.scan_busy, 1);
      chk("abort_detect", bus.dl_detect, 0);
      drive(1'b1, 1'b0, 4'hF, ring);
      run_until(40, at);
      chk("abort_latency", 10 + at, 22);

      // Self-loop on 3 plus ring 1<->2.
      restart();
      drive(1'b1, 1'b0, 4'b1110, edg(3,3) | edg(1,2) | edg(2,1)); tick();
      run_until(40, at);
      chk("self_latency", at, 11);
      chk("self_members", bus.dl_members, 4'b1110);
      chk("self_origin", bus.dl_origin, 4'b0010);

      // Asynchronous reset in the middle of SCAN.
      restart();
      drive(1'b1, 1'b0, 4'hF, ring); tick();
      repeat (9) tick();
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("rst_scan_busy", bus.scan_busy, 0);
      chk("rst_scan_out", {bus.dl_detect, bus.dl_members, bus.dl_origin}, 0);
      @(negedge clock); #1 reset = 1'b1;

      // Clear on the final SCAN cycle wins over the detection.
      restart();
      drive(1'b1, 1'b0, 4'hF, ring); tick();
      repeat (10) tick();
      drive(1'b1, 1'b1, 4'hF, ring); tick();
      drive(1'b1, 1'b0, 4'hF, ring);
      chk("clr_scan_detect", bus.dl_detect, 0);
      chk("clr_scan_members", bus.dl_members, 0);
      chk("clr_scan_busy", bus.scan_busy, 0);

      // Two-process instance: 0->1, 1->0.
      bus2.enable = 1'b0; bus2.clear = 1'b1; tick();
      bus2.enable = 1'b1; bus2.clear = 1'b0; tick();
      bus2.blocked = 2'b11; bus2.wait_vec = 4'b0110; tick();
      at = -1;
      for (int c = 1; c <= 30 && at < 0; c++) begin
         tick();
         if (bus2.dl_detect) at = c;
      end
      chk("n2_latency", at, 9);
      chk("n2_members", bus2.dl_members, 2'b11);
      chk("n2_origin", bus2.dl_origin, 2'b01);

      // Random graphs, glitches, clears and enable drops against the model.
      restart();
      hold = 0; g = '0; bl = '0;
      for (int c = 0; c < 2500; c++) begin
         if (hold == 0) begin
            hold = $urandom_range(2, 28);
            case ($urandom_range(0, 3))
               0: g = ring;
               1: g = NN'($urandom) & NN'($urandom) & NN'($urandom);
               2: g = edg($urandom_range(0, 3), $urandom_range(0, 3)) | chain;
               default: g = NN'($urandom);
            endcase
            bl = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
         end
         hold--;
         b = bl;
         if ($urandom_range(0, 29) == 0) b[$urandom_range(0, 3)] = ~b[$urandom_range(0, 3)];
         drive($urandom_range(0, 59) != 0, $urandom_range(0, 39) == 0, b, g);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
